axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: 32-bit words of storage, power of two.
REQ-002 SHALL have port a_clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port a_resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port aw_id  in  4  write transaction ID.
REQ-005 SHALL have port aw_addr  in  32  write byte address.
REQ-006 SHALL have port aw_len  in  4  beats minus one.
REQ-007 SHALL have port aw_burst  in  2  00 FIXED, 01 INCR.
REQ-008 SHALL have port aw_valid  in  1  write address valid.
REQ-009 SHALL have port aw_ready  out  1  write address accepted.
REQ-010 SHALL have port w_data  in  32  write data.
REQ-011 SHALL have port w_strb  in  4  byte enables.
REQ-012 SHALL have port w_last  in  1  final beat.
REQ-013 SHALL have port w_valid  in  1  write data valid.
REQ-014 SHALL have port w_ready  out  1  write data accepted.
REQ-015 SHALL have port b_id  out  4  echoed aw_id.
REQ-016 SHALL have port b_resp  out  2  00 OKAY, 10 SLVERR.
REQ-017 SHALL have port b_valid  out  1  response valid.
REQ-018 SHALL have port b_ready  in  1  response accepted.
REQ-019 SHALL have port ar_id  in  4  read ID.
REQ-020 SHALL have port ar_addr  in  32  read byte address.
REQ-021 SHALL have port ar_len  in  4  beats minus one.
REQ-022 SHALL have port ar_burst  in  2  00 FIXED, 01 INCR.
REQ-023 SHALL have port ar_valid  in  1  read address valid.
REQ-024 SHALL have port ar_ready  out  1  read address accepted.
REQ-025 SHALL have port r_id  out  4  echoed ar_id.
REQ-026 SHALL have port r_data  out  32  read data.
REQ-027 SHALL have port r_resp  out  2  00 OKAY, 10 SLVERR.
REQ-028 SHALL have port r_last  out  1  final read beat.
REQ-029 SHALL have port r_valid  out  1  read data valid.
REQ-030 SHALL have port r_ready  in  1  read data accepted.

Function
REQ-031 Write FSM SHALL be W_IDLE -> W_DATA on aw handshake (latch id/addr/len/burst), W_DATA -> W_RESP on w handshake with beat count == len, W_RESP -> W_IDLE on b handshake; aw_ready=1 only in W_IDLE, w_ready=1 only in W_DATA, b_valid=1 only in W_RESP.
REQ-032 Read FSM SHALL be R_IDLE -> R_DATA on ar handshake, R_DATA -> R_IDLE on r handshake with r_last=1; ar_ready=1 only in R_IDLE; r_valid rises exactly one cycle after ar handshake; read and write FSMs independent.
REQ-033 Word index SHALL be addr[31:2]; bits [1:0] ignored; INCR adds 4 per beat, FIXED holds address; counters 4 bits, no wrap beyond len.
REQ-034 Each write beat SHALL update only bytes with w_strb set, in the cycle of the w handshake; w_strb=0 writes nothing, still OKAY.
REQ-035 A beat with word index >= DEPTH SHALL be suppressed (no write; r_data=0) and flagged; b_resp=10 if any beat of the burst flagged, r_resp=10 per flagged beat.
REQ-036 r_data, r_resp, r_last, r_id SHALL hold stable while r_valid=1 and r_ready=0; b_id, b_resp likewise while b_valid=1 and b_ready=0.
REQ-037 Read and write to the same word in the same cycle SHALL return the old data; write is visible to any read accepted one or more cycles later.
REQ-038 w_last SHALL be ignored for termination; w_last mismatching beat count SHALL force b_resp=10.

Reset
REQ-039 On a_resetn=0, asynchronously: both FSMs to IDLE, all counters 0, aw_ready=1, ar_ready=1, w_ready=0, b_valid=0, r_valid=0, r_last=0, b_resp=00, r_resp=00, b_id=0, r_id=0, r_data=0; memory contents undefined; reset mid-burst abandons the burst with no response.

Structure
REQ-040 Package axi_pkg SHALL hold resp codes, burst codes, write/read state enums; sub-module sram_1w1r (byte-enabled write, registered read, DEPTH words) SHALL hold storage.

Verification
REQ-041 aw 0x10 len0 FIXED, w 0xDEADBEEF strb F -> b OKAY id echoed; ar 0x10 -> r_data 0xDEADBEEF, r_last=1, one cycle after ar handshake.
REQ-042 INCR len3 at 0x100 data 1..4, read back INCR len3 -> 1,2,3,4, r_last only on beat 4.
REQ-043 Word 0x20 = 0xFFFFFFFF, write 0x12345678 strb 0101 -> read 0xFF34FF78.
REQ-044 Write addr DEPTH*4 -> b_resp=10, memory unchanged; read same -> r_resp=10, r_data=0.
REQ-045 Hold r_ready=0 and b_ready=0 for 5 cycles -> outputs stable, aw_ready/ar_ready stay 0; assert a_resetn=0 mid-INCR burst -> b_valid=0, r_valid=0 immediately.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI response/burst codes, FSM state types and a range helper
// for the single-port AXI SRAM slave.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // True when a 30-bit word index lands inside the backing store.
  function automatic logic in_range(input logic [29:0] idx, input int unsigned depth);
    return {2'b00, idx} < depth;
  endfunction

endpackage

// File: rtl/sram_1w1r.sv
// Word-wide storage with one byte-enabled write port and one registered
// read port. A read and a write to the same word in one cycle return the
// old contents.
module sram_1w1r #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write; lanes with a clear strobe keep their old value.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read that only moves when a new word is requested, so the
  // output holds steady while the requester stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI-style burst slave in front of a 1W1R SRAM. Independent write and
// read state machines; out-of-range beats are suppressed and reported
// as SLVERR.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        a_clk,
  input  logic        a_resetn,
  input  logic [3:0]  aw_id,
  input  logic [31:0] aw_addr,
  input  logic [3:0]  aw_len,
  input  logic [1:0]  aw_burst,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  input  logic        w_last,
  input  logic        w_valid,
  output logic        w_ready,
  output logic [3:0]  b_id,
  output logic [1:0]  b_resp,
  output logic        b_valid,
  input  logic        b_ready,
  input  logic [3:0]  ar_id,
  input  logic [31:0] ar_addr,
  input  logic [3:0]  ar_len,
  input  logic [1:0]  ar_burst,
  input  logic        ar_valid,
  output logic        ar_ready,
  output logic [3:0]  r_id,
  output logic [31:0] r_data,
  output logic [1:0]  r_resp,
  output logic        r_last,
  output logic        r_valid,
  input  logic        r_ready
);

  localparam int AW = $clog2(DEPTH);

  wr_state_t   wr_state;
  logic [3:0]  wr_id;
  logic [29:0] wr_idx;
  logic [3:0]  wr_len;
  logic [1:0]  wr_burst;
  logic [3:0]  wr_cnt;
  logic        wr_err;
  logic        wr_last_beat;
  logic        wr_oob;
  logic        beat_err;
  logic        mem_we;

  rd_state_t   rd_state;
  logic [3:0]  rd_len;
  logic [1:0]  rd_burst;
  logic [3:0]  rd_cnt;
  logic [29:0] rd_idx;
  logic [29:0] rd_fetch_idx;
  logic        r_oob;
  logic        ar_hs;
  logic        mem_re;
  logic [31:0] sram_q;

  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^{aw_addr[1:0], ar_addr[1:0]};

  assign aw_ready = (wr_state == W_IDLE);
  assign w_ready  = (wr_state == W_DATA);
  assign b_valid  = (wr_state == W_RESP);

  assign wr_last_beat = (wr_cnt == wr_len);
  assign wr_oob       = !in_range(wr_idx, DEPTH);
  assign beat_err     = wr_oob | (w_last != wr_last_beat);
  assign mem_we       = w_valid & w_ready & !wr_oob;

  // Write channel: latch the burst, count beats against len, then hold the
  // response until it is taken. w_last only feeds the error flag.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      wr_state <= W_IDLE;
      wr_id    <= '0;
      wr_idx   <= '0;
      wr_len   <= '0;
      wr_burst <= BURST_FIXED;
      wr_cnt   <= '0;
      wr_err   <= 1'b0;
      b_id     <= '0;
      b_resp   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_valid) begin
            wr_state <= W_DATA;
            wr_id    <= aw_id;
            wr_idx   <= aw_addr[31:2];
            wr_len   <= aw_len;
            wr_burst <= aw_burst;
            wr_cnt   <= '0;
            wr_err   <= 1'b0;
          end
        end
        W_DATA: begin
          if (w_valid) begin
            if (wr_last_beat) begin
              wr_state <= W_RESP;
              b_id     <= wr_id;
              b_resp   <= (wr_err | beat_err) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              wr_cnt <= wr_cnt + 4'd1;
              wr_err <= wr_err | beat_err;
              if (wr_burst == BURST_INCR) begin
                wr_idx <= wr_idx + 30'd1;
              end
            end
          end
        end
        W_RESP: begin
          if (b_ready) begin
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign ar_ready = (rd_state == R_IDLE);
  assign r_valid  = (rd_state == R_DATA);
  assign ar_hs    = ar_valid & ar_ready;

  assign rd_fetch_idx = ar_hs ? ar_addr[31:2] :
                        ((rd_burst == BURST_INCR) ? rd_idx + 30'd1 : rd_idx);
  assign mem_re       = ar_hs | (r_valid & r_ready & !r_last);

  assign r_data = r_oob ? 32'h0 : sram_q;
  assign r_resp = r_oob ? RESP_SLVERR : RESP_OKAY;

  // Read channel: each accepted beat fetches the next word, so data for
  // beat n+1 is ready the cycle after beat n is taken.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      rd_state <= R_IDLE;
      rd_len   <= '0;
      rd_burst <= BURST_FIXED;
      rd_cnt   <= '0;
      rd_idx   <= '0;
      r_id     <= '0;
      r_last   <= 1'b0;
      r_oob    <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_valid) begin
            rd_state <= R_DATA;
            r_id     <= ar_id;
            rd_len   <= ar_len;
            rd_burst <= ar_burst;
            rd_cnt   <= '0;
            rd_idx   <= rd_fetch_idx;
            r_last   <= (ar_len == 4'd0);
            r_oob    <= !in_range(rd_fetch_idx, DEPTH);
          end
        end
        R_DATA: begin
          if (r_ready) begin
            if (r_last) begin
              rd_state <= R_IDLE;
              r_last   <= 1'b0;
              r_oob    <= 1'b0;
            end else begin
              rd_cnt <= rd_cnt + 4'd1;
              rd_idx <= rd_fetch_idx;
              r_last <= ((rd_cnt + 4'd1) == rd_len);
              r_oob  <= !in_range(rd_fetch_idx, DEPTH);
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  sram_1w1r #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (a_clk),
    .rst_n (a_resetn),
    .we    (mem_we),
    .waddr (wr_idx[AW-1:0]),
    .wdata (w_data),
    .wstrb (w_strb),
    .re    (mem_re),
    .raddr (rd_fetch_idx[AW-1:0]),
    .rdata (sram_q)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: tasks issue bursts and push the
// responses a plain word-array model predicts; a negedge monitor compares
// every presented response against the queue head.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int DEPTH = 128;

  logic        a_clk = 1'b0;
  logic        a_resetn;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [3:0]  aw_len, ar_len, w_strb;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready;

  axi_sram_slave #(.DEPTH(DEPTH)) dut (
    .a_clk(a_clk), .a_resetn(a_resetn),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_burst(aw_burst),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_burst(ar_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 a_clk = ~a_clk;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  bit          aborted = 0;
  int          ready_pct = 70;
  logic [31:0] model_mem [DEPTH];
  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  logic [31:0] data_buf [16];
  logic [3:0]  strb_buf [16];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic bit chan_ok(input int ch);
    case (ch)
      0:       return aw_ready;
      1:       return w_ready;
      2:       return b_valid && b_ready;
      3:       return ar_ready;
      default: return r_valid && r_ready;
    endcase
  endfunction

  // Wait for a handshake on one channel, re-rolling the response ready
  // each missed cycle; returns just after the handshake edge.
  task automatic wait_chan(input int ch, input string name);
    int  n = 0;
    bit  done = 0;
    while (!done && !aborted) begin
      @(negedge a_clk);
      if (chan_ok(ch)) begin
        @(posedge a_clk);
        #1;
        done = 1;
      end else begin
        n++;
        if (n >= 200) begin
          check_output({name, "_timeout"}, 32'd0, 32'd1);
          aborted = 1;
        end else begin
          @(posedge a_clk);
          #1;
          if (ch == 2) b_ready = ($urandom_range(0, 99) < ready_pct);
          if (ch == 4) r_ready = ($urandom_range(0, 99) < ready_pct);
        end
      end
    end
  endtask

  // Model a read burst: one expected beat per word, zero data and SLVERR
  // for words past the end of storage.
  task automatic push_read_expect(input logic [3:0] id, input logic [31:0] addr,
                                  input logic [3:0] len, input logic [1:0] burst);
    for (int i = 0; i <= int'(len); i++) begin
      int unsigned widx = int'(addr[31:2]) + ((burst == BURST_INCR) ? i : 0);
      r_exp_t e;
      e.id   = id;
      e.last = (i == int'(len));
      if (widx >= DEPTH) begin
        e.data = 32'h0;
        e.resp = RESP_SLVERR;
      end else begin
        e.data = model_mem[widx];
        e.resp = RESP_OKAY;
      end
      r_q.push_back(e);
    end
  endtask

  task automatic apply_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input bit bad_last, input int hold);
    bit err = bad_last;
    int bad_beat = $urandom_range(0, int'(len));
    if (aborted) return;
    for (int i = 0; i <= int'(len); i++) begin
      int unsigned widx = int'(addr[31:2]) + ((burst == BURST_INCR) ? i : 0);
      if (widx >= DEPTH) begin
        err = 1;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (strb_buf[i][b]) model_mem[widx][b*8 +: 8] = data_buf[i][b*8 +: 8];
        end
      end
    end
    b_q.push_back('{id: id, resp: (err ? RESP_SLVERR : RESP_OKAY)});
    aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst; aw_valid = 1'b1;
    wait_chan(0, "aw");
    aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_data  = data_buf[i];
      w_strb  = strb_buf[i];
      w_last  = (i == int'(len)) ^ (bad_last && i == bad_beat);
      w_valid = 1'b1;
      wait_chan(1, "w");
    end
    w_valid = 1'b0;
    b_ready = 1'b0;
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge a_clk);
        check_output("b_valid_stall", 32'(b_valid), 32'd1);
      end
      @(posedge a_clk);
      #1;
    end
    b_ready = ($urandom_range(0, 99) < ready_pct);
    wait_chan(2, "b");
    b_ready = 1'b0;
  endtask

  task automatic apply_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input int hold);
    if (aborted) return;
    push_read_expect(id, addr, len, burst);
    ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst; ar_valid = 1'b1;
    r_ready = 1'b0;
    wait_chan(3, "ar");
    ar_valid = 1'b0;
    if (aborted) return;
    #3;
    check_output("r_valid_latency", 32'(r_valid), 32'd1);
    if (hold > 0) begin
      repeat (hold) @(negedge a_clk);
      @(posedge a_clk);
      #1;
    end
    r_ready = ($urandom_range(0, 99) < ready_pct);
    for (int i = 0; i <= int'(len); i++) wait_chan(4, "r");
    r_ready = 1'b0;
  endtask

  // Fill every word with known data so any later read has a defined answer.
  task automatic init_memory();
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin
        data_buf[i] = $urandom;
        strb_buf[i] = 4'hF;
      end
      apply_write(4'(k), 32'(k * 64), 4'd15, BURST_INCR, 0, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_aw_ready"}, 32'(aw_ready), 32'd1);
    check_output({tag, "_ar_ready"}, 32'(ar_ready), 32'd1);
    check_output({tag, "_w_ready"},  32'(w_ready),  32'd0);
    check_output({tag, "_b_valid"},  32'(b_valid),  32'd0);
    check_output({tag, "_r_valid"},  32'(r_valid),  32'd0);
    check_output({tag, "_r_last"},   32'(r_last),   32'd0);
    check_output({tag, "_b_resp"},   32'(b_resp),   32'd0);
    check_output({tag, "_r_resp"},   32'(r_resp),   32'd0);
    check_output({tag, "_b_id"},     32'(b_id),     32'd0);
    check_output({tag, "_r_id"},     32'(r_id),     32'd0);
    check_output({tag, "_r_data"},   r_data,        32'd0);
  endtask

  task automatic clear_inputs();
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = '0; ar_valid = 1'b0; r_ready = 1'b0;
  endtask

  // Scoreboard monitor: while a response is presented it must match the
  // queue head every cycle (covers stall stability); pop on handshake.
  always @(negedge a_clk) begin
    if (a_resetn === 1'b1 && !aborted) begin
      if (b_valid) begin
        check_output("aw_ready_during_b", 32'(aw_ready), 32'd0);
        if (b_q.size() == 0) begin
          check_output("b_unexpected", 32'd1, 32'd0);
        end else begin
          check_output("b_id", 32'(b_id), 32'(b_q[0].id));
          check_output("b_resp", 32'(b_resp), 32'(b_q[0].resp));
          if (b_ready) void'(b_q.pop_front());
        end
      end
      if (r_valid) begin
        check_output("ar_ready_during_r", 32'(ar_ready), 32'd0);
        if (r_q.size() == 0) begin
          check_output("r_unexpected", 32'd1, 32'd0);
        end else begin
          check_output("r_id", 32'(r_id), 32'(r_q[0].id));
          check_output("r_data", r_data, r_q[0].data);
          check_output("r_resp", 32'(r_resp), 32'(r_q[0].resp));
          check_output("r_last", 32'(r_last), 32'(r_q[0].last));
          if (r_ready) void'(r_q.pop_front());
        end
      end
    end
  end

  // Apply asynchronous reset in the middle of an INCR write burst while a
  // read burst is stalled; both channels must drop at once.
  task automatic reset_mid_burst();
    if (aborted) return;
    push_read_expect(4'h9, 32'h40, 4'd3, BURST_INCR);
    ar_id = 4'h9; ar_addr = 32'h40; ar_len = 4'd3; ar_burst = BURST_INCR; ar_valid = 1'b1;
    r_ready = 1'b0;
    wait_chan(3, "ar_rst");
    ar_valid = 1'b0;
    aw_id = 4'hA; aw_addr = 32'h0; aw_len = 4'd7; aw_burst = BURST_INCR; aw_valid = 1'b1;
    wait_chan(0, "aw_rst");
    aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_data = $urandom; w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
      wait_chan(1, "w_rst");
    end
    if (aborted) return;
    #2;
    a_resetn = 1'b0;
    clear_inputs();
    r_q.delete();
    b_q.delete();
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(posedge a_clk);
    #3;
    a_resetn = 1'b1;
  endtask

  initial begin
    a_resetn = 1'b0;
    clear_inputs();
    #12;
    check_reset_outputs("rst");
    @(posedge a_clk);
    #3;
    a_resetn = 1'b1;
    @(posedge a_clk);
    #1;

    init_memory();

    data_buf[0] = 32'hDEADBEEF; strb_buf[0] = 4'hF;
    apply_write(4'h3, 32'h10, 4'd0, BURST_FIXED, 0, 0);
    apply_read(4'h5, 32'h10, 4'd0, BURST_FIXED, 0);

    for (int i = 0; i < 4; i++) begin data_buf[i] = 32'(i + 1); strb_buf[i] = 4'hF; end
    apply_write(4'h1, 32'h100, 4'd3, BURST_INCR, 0, 0);
    apply_read(4'h2, 32'h100, 4'd3, BURST_INCR, 0);

    data_buf[0] = 32'hFFFFFFFF; strb_buf[0] = 4'hF;
    apply_write(4'h6, 32'h80, 4'd0, BURST_FIXED, 0, 0);
    data_buf[0] = 32'h12345678; strb_buf[0] = 4'b0101;
    apply_write(4'h7, 32'h80, 4'd0, BURST_FIXED, 0, 0);
    data_buf[0] = 32'hCAFEF00D; strb_buf[0] = 4'h0;
    apply_write(4'h8, 32'h80, 4'd0, BURST_FIXED, 0, 0);
    apply_read(4'h8, 32'h80, 4'd0, BURST_FIXED, 0);

    data_buf[0] = 32'hABCDEF01; strb_buf[0] = 4'hF;
    apply_write(4'hB, 32'(DEPTH * 4), 4'd0, BURST_FIXED, 0, 0);
    apply_read(4'hC, 32'(DEPTH * 4), 4'd0, BURST_FIXED, 0);
    apply_read(4'hD, 32'h0, 4'd0, BURST_FIXED, 0);

    for (int i = 0; i < 4; i++) begin data_buf[i] = $urandom; strb_buf[i] = 4'hF; end
    apply_write(4'hE, 32'((DEPTH - 2) * 4), 4'd3, BURST_INCR, 0, 0);
    apply_read(4'hF, 32'((DEPTH - 2) * 4), 4'd3, BURST_INCR, 0);
    apply_write(4'h4, 32'h30, 4'd3, BURST_FIXED, 0, 0);
    apply_read(4'h4, 32'h30, 4'd2, BURST_FIXED, 0);
    apply_write(4'h2, 32'h50, 4'd3, BURST_INCR, 1, 0);

    apply_write(4'h5, 32'h60, 4'd2, BURST_INCR, 0, 5);
    apply_read(4'h6, 32'h60, 4'd3, BURST_INCR, 5);

    reset_mid_burst();
    init_memory();

    for (int t = 0; t < 60 && !aborted; t++) begin
      logic [3:0]  id    = 4'($urandom);
      logic [3:0]  len   = 4'($urandom);
      logic [1:0]  burst = ($urandom_range(0, 1) == 1) ? BURST_INCR : BURST_FIXED;
      logic [31:0] addr  = 32'($urandom_range(0, DEPTH + 3) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin data_buf[i] = $urandom; strb_buf[i] = 4'($urandom); end
        apply_write(id, addr, len, burst, ($urandom_range(0, 7) == 0), 0);
      end else begin
        apply_read(id, addr, len, burst, 0);
      end
    end

    repeat (3) @(posedge a_clk);
    if (!aborted) begin
      check_output("b_queue_empty", 32'(b_q.size()), 32'd0);
      check_output("r_queue_empty", 32'(r_q.size()), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
